// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display slice.
// Segment constants are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes A..F show a dash so corrupted digits are visible on the panel.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg_n
);

    always_comb begin
        case (digit)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            // NOTE: the default arm covers every remaining code, so no latch can be inferred.
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_7seg_scan.sv
// Multiplexed N-digit 7-segment scanner with per-frame snapshot and anode guard.
// Define DISP_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module disp_7seg_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int GUARD_CYC = 50
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] bcd,
    input  logic [N_DIGITS-1:0]   dp,
    output logic [N_DIGITS-1:0]   an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);

    logic [IW-1:0]             idx, idx_nxt;
    bcd_t [N_DIGITS-1:0]       snap_bcd, snap_bcd_nxt;
    logic [N_DIGITS-1:0]       snap_dp, snap_dp_nxt;
    logic [GW-1:0]             guard_cnt, guard_nxt;
    logic                      started, started_nxt;
    logic                      wrap;
    logic                      blank;
    logic [6:0]                seg_dec;

    // Outputs are registered from next-state values so a new digit shows one cycle after en.
    always_comb begin
        wrap         = en && (idx == IDX_LAST);
        idx_nxt      = idx;
        snap_bcd_nxt = snap_bcd;
        snap_dp_nxt  = snap_dp;
        if (en)
            idx_nxt = wrap ? '0 : idx + 1'b1;
        if (wrap) begin
            snap_bcd_nxt = bcd;
            snap_dp_nxt  = dp;
        end
        if (en)
            guard_nxt = GUARD_LOAD;
        else if (guard_cnt != '0)
            guard_nxt = guard_cnt - 1'b1;
        else
            guard_nxt = guard_cnt;
        started_nxt = started | en;
    end

    bcd_to_7seg u_dec (
        .digit (snap_bcd_nxt[idx_nxt]),
        .seg_n (seg_dec)
    );

`ifdef DISP_LEAD_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] lz;

    // A digit is blanked when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        lz         = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            above_zero = above_zero && (snap_bcd_nxt[k] == 4'd0);
            lz[k]      = above_zero;
        end
    end

    assign blank = lz[idx_nxt];
`else
    assign blank = 1'b0;
`endif

    // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset along with the rest.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            snap_bcd  <= '0;
            snap_dp   <= '0;
            guard_cnt <= '0;
            started   <= 1'b0;
            frame     <= 1'b0;
            an_n      <= '1;
            seg_n     <= SEG_OFF;
            dp_n      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            idx       <= idx_nxt;
            snap_bcd  <= snap_bcd_nxt;
            snap_dp   <= snap_dp_nxt;
            guard_cnt <= guard_nxt;
            started   <= started_nxt;
            frame     <= wrap;
            seg_n     <= (started_nxt && !blank) ? seg_dec : SEG_OFF;
            dp_n      <= started_nxt ? ~snap_dp_nxt[idx_nxt] : 1'b1;
            an_n      <= (started_nxt && guard_nxt == '0)
                         ? ~(N_DIGITS'(1) << idx_nxt) : '1;
        end
    end

endmodule

// File: tb/tb_disp_7seg_scan.sv
// Directed self-checking bench for disp_7seg_scan (guard 2 and guard 50 instances).
// Expected values are hand-computed segment patterns; leading-zero checks follow DISP_LEAD_ZERO_BLANK_EN.
module tb_disp_7seg_scan;

    logic        mclk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  an_n,   an_n_g;
    logic [6:0]  seg_n,  seg_n_g;
    logic        dp_n,   dp_n_g;
    logic        frame,  frame_g;

    int errors = 0;
    int checks = 0;

`ifdef DISP_LEAD_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    always #10 mclk = ~mclk;

    disp_7seg_scan #(.N_DIGITS(4), .GUARD_CYC(2)) u_dut (
        .mclk  (mclk),
        .reset (reset),
        .en    (en),
        .bcd   (bcd),
        .dp    (dp),
        .an_n  (an_n),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .frame (frame)
    );

    disp_7seg_scan #(.N_DIGITS(4), .GUARD_CYC(50)) u_g50 (
        .mclk  (mclk),
        .reset (reset),
        .en    (en),
        .bcd   (bcd),
        .dp    (dp),
        .an_n  (an_n_g),
        .seg_n (seg_n_g),
        .dp_n  (dp_n_g),
        .frame (frame_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"},    32'(an_n),  32'hF);
        check({tag, "_seg"},   32'(seg_n), 32'h7F);
        check({tag, "_dp"},    32'(dp_n),  32'h1);
        check({tag, "_frame"}, 32'(frame), 32'h0);
    endtask

    // One en pulse, then 10 cycles total: seg/dp/frame right after, anode after 2 guard cycles.
    task automatic scan_step(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dpn,
                             input logic exp_frame);
        @(negedge mclk) en = 1'b1;
        @(negedge mclk) en = 1'b0;
        check({tag, "_seg"},    32'(seg_n), 32'(exp_seg));
        check({tag, "_dp"},     32'(dp_n),  32'(exp_dpn));
        check({tag, "_frame"},  32'(frame), 32'(exp_frame));
        check({tag, "_guard0"}, 32'(an_n),  32'hF);
        @(negedge mclk);
        check({tag, "_guard1"}, 32'(an_n),  32'hF);
        check({tag, "_fpulse"}, 32'(frame), 32'h0);
        @(negedge mclk);
        check({tag, "_an"},     32'(an_n),  32'(exp_an));
        repeat (7) @(negedge mclk);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        bcd   = 16'h1234;
        dp    = 4'b0100;

        repeat (5) @(negedge mclk);
        check_blank("rst_hold");
        reset = 1'b1;
        repeat (100) @(negedge mclk);
        check_blank("rst_idle");

        // First frame runs from the zero snapshot taken at reset.
        scan_step("pre1", 4'hD, LZ, 1'b1, 1'b0);
        scan_step("pre2", 4'hB, LZ, 1'b1, 1'b0);
        scan_step("pre3", 4'h7, LZ, 1'b1, 1'b0);

        // Frame showing 1234 with dp on digit 2.
        scan_step("f1_d0", 4'hE, 7'h19, 1'b1, 1'b1);
        scan_step("f1_d1", 4'hD, 7'h30, 1'b1, 1'b0);
        scan_step("f1_d2", 4'hB, 7'h24, 1'b0, 1'b0);
        scan_step("f1_d3", 4'h7, 7'h79, 1'b1, 1'b0);

        // Input changes mid-frame must not reach the display until the next wrap.
        scan_step("f2_d0", 4'hE, 7'h19, 1'b1, 1'b1);
        scan_step("f2_d1", 4'hD, 7'h30, 1'b1, 1'b0);
        bcd = 16'h5678;
        scan_step("f2_d2", 4'hB, 7'h24, 1'b0, 1'b0);
        scan_step("f2_d3", 4'h7, 7'h79, 1'b1, 1'b0);

        scan_step("f3_d0", 4'hE, 7'h00, 1'b1, 1'b1);
        scan_step("f3_d1", 4'hD, 7'h78, 1'b1, 1'b0);
        scan_step("f3_d2", 4'hB, 7'h02, 1'b0, 1'b0);
        bcd = 16'hF0A9;
        scan_step("f3_d3", 4'h7, 7'h12, 1'b1, 1'b0);

        // Invalid BCD codes show a dash; digit 2 is zero but F above it keeps it lit.
        scan_step("inv_d0", 4'hE, 7'h10, 1'b1, 1'b1);
        scan_step("inv_d1", 4'hD, 7'h3F, 1'b1, 1'b0);
        scan_step("inv_d2", 4'hB, 7'h40, 1'b0, 1'b0);
        bcd = 16'h0070;
        dp  = 4'b0000;
        scan_step("inv_d3", 4'h7, 7'h3F, 1'b1, 1'b0);

        scan_step("lz_d0", 4'hE, 7'h40, 1'b1, 1'b1);
        scan_step("lz_d1", 4'hD, 7'h78, 1'b1, 1'b0);
        scan_step("lz_d2", 4'hB, LZ,    1'b1, 1'b0);
        bcd = 16'h0000;
        dp  = 4'b1000;
        scan_step("lz_d3", 4'h7, LZ,    1'b1, 1'b0);

        scan_step("z_d0", 4'hE, 7'h40, 1'b1, 1'b1);
        scan_step("z_d1", 4'hD, LZ,    1'b1, 1'b0);
        scan_step("z_d2", 4'hB, LZ,    1'b1, 1'b0);
        scan_step("z_d3", 4'h7, LZ,    1'b0, 1'b0);

        // en held high: every cycle restarts the guard, so no anode ever turns on.
        @(negedge mclk) en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge mclk);
            check("cont_an_g2",  32'(an_n),   32'hF);
            check("cont_an_g50", 32'(an_n_g), 32'hF);
        end
        en = 1'b0;
        repeat (4) @(negedge mclk);
        check("settle_an_g2_on",  32'(an_n == 4'hF), 32'h0);
        check("settle_an_g50",    32'(an_n_g),       32'hF);

        // Asynchronous reset mid-guard: blank before any further clock edge.
        reset = 1'b0;
        #1;
        check_blank("rst_async");
        check("rst_async_g50_seg", 32'(seg_n_g), 32'h7F);
        @(negedge mclk);
        reset = 1'b1;
        bcd   = 16'h9999;
        dp    = 4'b1111;
        repeat (3) @(negedge mclk);
        check_blank("rst_again");

        // The snapshot was discarded: first digit after reset comes from zeros.
        scan_step("post_d1", 4'hD, LZ, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
